deparser_queue_merger: RTL and testbench

- Sits directly downstream of the parser and its four packet-cache FIFOs.
- Takes each PHV and decodes the one-hot queue ID the parser placed in bits [144:141]. Drains exactly one packet from that cache queue onto a single AXI-Stream toward the deparser.
- Holds the PHV stable for the whole packet, so the deparser sees each packet paired with its own header vector.

---
 rtl/deparser_queue_merger.sv | 166 ++++++++++++++++
 tb/tb_deparser_queue_merger.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deparser_queue_merger.sv
// Merges the four parser cache queues onto one AXI-Stream, one packet per PHV, steered by the PHV's one-hot queue ID.
// Optional build macro QUEUE_ORDER_CHECK_EN: additionally enforces round-robin queue order 0,1,2,3.
module deparser_queue_merger #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PKT_HDR_LEN          = 2304,
    parameter int QID_LSB              = 141,
    parameter int ERR_CNT_WIDTH        = 16
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic [PKT_HDR_LEN-1:0]            phv_in,
    input  logic                              phv_in_valid,
    output logic                              phv_in_ready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_0,
    input  logic                              s_axis_tlast_0,
    input  logic                              s_axis_tvalid_0,
    output logic                              s_axis_tready_0,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_1,
    input  logic                              s_axis_tlast_1,
    input  logic                              s_axis_tvalid_1,
    output logic                              s_axis_tready_1,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_2,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_2,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_2,
    input  logic                              s_axis_tlast_2,
    input  logic                              s_axis_tvalid_2,
    output logic                              s_axis_tready_2,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_3,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_3,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_3,
    input  logic                              s_axis_tlast_3,
    input  logic                              s_axis_tvalid_3,
    output logic                              s_axis_tready_3,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [PKT_HDR_LEN-1:0]            phv_out,
    output logic                              phv_out_valid,
    output logic [ERR_CNT_WIDTH-1:0]          err_cnt
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0] state;
    logic [3:0] sel;
    logic [3:0] qid;
    logic       qid_onehot;
    logic       qid_ok;
    logic       phv_hs;
    logic       last_beat;
    logic       streaming;

    assign qid        = phv_in[QID_LSB +: 4];
    assign qid_onehot = (qid != 4'b0000) && ((qid & (qid - 4'd1)) == 4'b0000);
    assign streaming  = (state == STREAM);

`ifdef QUEUE_ORDER_CHECK_EN
    logic [1:0] exp_ptr;

    // A correctly formed qid is still rejected when it arrives out of round-robin turn.
    assign qid_ok = qid_onehot && (qid == (4'b0001 << exp_ptr));

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            exp_ptr <= 2'd0;
        end else if (phv_hs && qid_ok) begin
            exp_ptr <= exp_ptr + 2'd1;
        end
    end
`else
    assign qid_ok = qid_onehot;
`endif

    assign phv_in_ready = (state == IDLE);
    assign phv_hs       = phv_in_ready && phv_in_valid;

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tuser  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        case (sel)
            4'b0001: begin
                m_axis_tdata  = s_axis_tdata_0;
                m_axis_tuser  = s_axis_tuser_0;
                m_axis_tkeep  = s_axis_tkeep_0;
                m_axis_tlast  = s_axis_tlast_0;
                m_axis_tvalid = streaming && s_axis_tvalid_0;
            end
            4'b0010: begin
                m_axis_tdata  = s_axis_tdata_1;
                m_axis_tuser  = s_axis_tuser_1;
                m_axis_tkeep  = s_axis_tkeep_1;
                m_axis_tlast  = s_axis_tlast_1;
                m_axis_tvalid = streaming && s_axis_tvalid_1;
            end
            4'b0100: begin
                m_axis_tdata  = s_axis_tdata_2;
                m_axis_tuser  = s_axis_tuser_2;
                m_axis_tkeep  = s_axis_tkeep_2;
                m_axis_tlast  = s_axis_tlast_2;
                m_axis_tvalid = streaming && s_axis_tvalid_2;
            end
            4'b1000: begin
                m_axis_tdata  = s_axis_tdata_3;
                m_axis_tuser  = s_axis_tuser_3;
                m_axis_tkeep  = s_axis_tkeep_3;
                m_axis_tlast  = s_axis_tlast_3;
                m_axis_tvalid = streaming && s_axis_tvalid_3;
            end
            default: ;
        endcase
    end

    // Only the selected queue ever sees ready; the others are left untouched.
    assign s_axis_tready_0 = streaming && sel[0] && m_axis_tready;
    assign s_axis_tready_1 = streaming && sel[1] && m_axis_tready;
    assign s_axis_tready_2 = streaming && sel[2] && m_axis_tready;
    assign s_axis_tready_3 = streaming && sel[3] && m_axis_tready;

    assign last_beat = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state         <= IDLE;
            sel           <= 4'b0000;
            phv_out       <= '0;
            phv_out_valid <= 1'b0;
            err_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (phv_hs) begin
                        phv_out <= phv_in;
                        if (qid_ok) begin
                            sel           <= qid;
                            phv_out_valid <= 1'b1;
                            state         <= STREAM;
                        end else if (err_cnt != '1) begin
                            err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
                        end
                    end
                end
                STREAM: begin
                    if (last_beat) begin
                        sel           <= 4'b0000;
                        phv_out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deparser_queue_merger.sv
// Directed, self-checking bench for deparser_queue_merger: one task per scenario, expected values hand-computed.
// Build with QUEUE_ORDER_CHECK_EN defined to exercise the round-robin order check instead of the free-order scenarios.
module tb_deparser_queue_merger;

    localparam int DW  = 256;
    localparam int UW  = 128;
    localparam int HL  = 2304;
    localparam int QL  = 141;
    localparam int EW  = 16;

    logic              axis_clk = 1'b0;
    logic              aresetn;
    logic [HL-1:0]     phv_in;
    logic              phv_in_valid;
    logic              phv_in_ready;
    logic [DW-1:0]     td [4];
    logic [UW-1:0]     tu [4];
    logic [DW/8-1:0]   tk [4];
    logic              tl [4];
    logic              tv [4];
    logic              tr [4];
    logic [DW-1:0]     m_axis_tdata;
    logic [UW-1:0]     m_axis_tuser;
    logic [DW/8-1:0]   m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [HL-1:0]     phv_out;
    logic              phv_out_valid;
    logic [EW-1:0]     err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 axis_clk = ~axis_clk;

    deparser_queue_merger dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .phv_in          (phv_in),
        .phv_in_valid    (phv_in_valid),
        .phv_in_ready    (phv_in_ready),
        .s_axis_tdata_0  (td[0]), .s_axis_tuser_0 (tu[0]), .s_axis_tkeep_0 (tk[0]),
        .s_axis_tlast_0  (tl[0]), .s_axis_tvalid_0(tv[0]), .s_axis_tready_0(tr[0]),
        .s_axis_tdata_1  (td[1]), .s_axis_tuser_1 (tu[1]), .s_axis_tkeep_1 (tk[1]),
        .s_axis_tlast_1  (tl[1]), .s_axis_tvalid_1(tv[1]), .s_axis_tready_1(tr[1]),
        .s_axis_tdata_2  (td[2]), .s_axis_tuser_2 (tu[2]), .s_axis_tkeep_2 (tk[2]),
        .s_axis_tlast_2  (tl[2]), .s_axis_tvalid_2(tv[2]), .s_axis_tready_2(tr[2]),
        .s_axis_tdata_3  (td[3]), .s_axis_tuser_3 (tu[3]), .s_axis_tkeep_3 (tk[3]),
        .s_axis_tlast_3  (tl[3]), .s_axis_tvalid_3(tv[3]), .s_axis_tready_3(tr[3]),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .phv_out         (phv_out),
        .phv_out_valid   (phv_out_valid),
        .err_cnt         (err_cnt)
    );

    // Advance one clock; inputs are then changed 1ns after the edge and outputs read 1ns later.
    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [HL-1:0] mk_phv(input logic [3:0] qid, input logic [15:0] tag);
        logic [HL-1:0] p;
        p = '0;
        p[QL +: 4] = qid;
        p[15:0] = tag;
        p[HL-1 -: 16] = ~tag;
        return p;
    endfunction

    // Load queue q with one beat: data/user/keep derived from tag so each beat is distinguishable.
    task automatic set_beat(input int q, input logic [15:0] tag, input logic last, input logic valid);
        td[q] = {16{tag}};
        tu[q] = {8{~tag}};
        tk[q] = {2{tag}};
        tl[q] = last;
        tv[q] = valid;
    endtask

    function automatic logic [3:0] readies();
        return {tr[3], tr[2], tr[1], tr[0]};
    endfunction

    task automatic clear_inputs();
        phv_in = '0;
        phv_in_valid = 1'b0;
        m_axis_tready = 1'b0;
        for (int q = 0; q < 4; q++) set_beat(q, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [HL-1:0] zero_phv;
        zero_phv = '0;
        clear_inputs();
        aresetn = 1'b0;
        tick(); tick();
        aresetn = 1'b1;
        for (int q = 0; q < 4; q++) set_beat(q, 16'h1111, 1'b0, 1'b1);
        m_axis_tready = 1'b1;
        settle();
        checks++; if (phv_in_ready !== 1'b1) begin errors++; $display("FAIL reset_phv_in_ready got %b exp 1", phv_in_ready); end
        checks++; if (phv_out_valid !== 1'b0) begin errors++; $display("FAIL reset_phv_out_valid got %b exp 0", phv_out_valid); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (phv_out !== zero_phv) begin errors++; $display("FAIL reset_phv_out got %h exp 0", phv_out[15:0]); end
        checks++; if (readies() !== 4'b0000 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_readies got %b/%b exp 0000/0", readies(), m_axis_tvalid); end
        clear_inputs();
    endtask

    task automatic test_three_beat();
        logic [HL-1:0] p;
        p = mk_phv(4'b0001, 16'hA001);
        phv_in = p; phv_in_valid = 1'b1; m_axis_tready = 1'b1;
        set_beat(0, 16'hB000, 1'b0, 1'b1);
        settle();
        checks++; if (m_axis_tvalid !== 1'b0 || tr[0] !== 1'b0) begin errors++; $display("FAIL tb3_idle_no_beat got %b/%b exp 0/0", m_axis_tvalid, tr[0]); end
        for (int b = 0; b < 3; b++) begin
            tick();
            phv_in_valid = 1'b0;
            set_beat(0, 16'hB000 + 16'(b), (b == 2), 1'b1);
            settle();
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {16{16'hB000 + 16'(b)}} || m_axis_tlast !== (b == 2))
                begin errors++; $display("FAIL tb3_beat%0d got v%b d%h l%b exp v1 d%h l%b", b, m_axis_tvalid, m_axis_tdata[15:0], m_axis_tlast, 16'hB000 + 16'(b), (b == 2)); end
            checks++; if (phv_out_valid !== 1'b1 || phv_in_ready !== 1'b0 || tr[0] !== 1'b1)
                begin errors++; $display("FAIL tb3_ctl%0d got pov%b pir%b tr%b exp 1 0 1", b, phv_out_valid, phv_in_ready, tr[0]); end
        end
        checks++; if (phv_out !== p) begin errors++; $display("FAIL tb3_phv_out got %h exp %h", phv_out[15:0], p[15:0]); end
        checks++; if (m_axis_tuser !== {8{~16'hB002}} || m_axis_tkeep !== {2{16'hB002}})
            begin errors++; $display("FAIL tb3_user_keep got %h/%h", m_axis_tuser[15:0], m_axis_tkeep); end
        tick();
        set_beat(0, 16'h0, 1'b0, 1'b0);
        settle();
        checks++; if (phv_in_ready !== 1'b1 || phv_out_valid !== 1'b0 || m_axis_tvalid !== 1'b0)
            begin errors++; $display("FAIL tb3_after got pir%b pov%b mv%b exp 1 0 0", phv_in_ready, phv_out_valid, m_axis_tvalid); end
        checks++; if (phv_out !== p) begin errors++; $display("FAIL tb3_phv_hold got %h exp %h", phv_out[15:0], p[15:0]); end
    endtask

    task automatic test_back_to_back();
        m_axis_tready = 1'b1;
        for (int q = 0; q < 4; q++) begin
            phv_in = mk_phv(4'b0001 << q, 16'hC000 + 16'(q)); phv_in_valid = 1'b1;
            set_beat(q, 16'hD000 + 16'(q), 1'b1, 1'b1);
            settle();
            checks++; if (phv_in_ready !== 1'b1 || m_axis_tvalid !== 1'b0)
                begin errors++; $display("FAIL b2b_idle%0d got pir%b mv%b exp 1 0", q, phv_in_ready, m_axis_tvalid); end
            tick();
            phv_in_valid = 1'b0;
            settle();
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {16{16'hD000 + 16'(q)}} || readies() !== (4'b0001 << q))
                begin errors++; $display("FAIL b2b_beat%0d got d%h rdy%b exp d%h rdy%b", q, m_axis_tdata[15:0], readies(), 16'hD000 + 16'(q), 4'b0001 << q); end
            tick();
            set_beat(q, 16'h0, 1'b0, 1'b0);
        end
        settle();
        checks++; if (err_cnt !== 16'd0 || phv_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_end got err%0d pir%b exp 0 1", err_cnt, phv_in_ready); end
    endtask

    task automatic test_discard();
        for (int q = 0; q < 4; q++) set_beat(q, 16'hE000 + 16'(q), 1'b1, 1'b1);
        m_axis_tready = 1'b1;
        phv_in = mk_phv(4'b0000, 16'h0E00); phv_in_valid = 1'b1;
        tick();
        phv_in = mk_phv(4'b0110, 16'h0E01);
        settle();
        checks++; if (err_cnt !== 16'd1 || phv_in_ready !== 1'b1 || readies() !== 4'b0000)
            begin errors++; $display("FAIL disc_zero got err%0d pir%b rdy%b exp 1 1 0000", err_cnt, phv_in_ready, readies()); end
        tick();
        phv_in_valid = 1'b0;
        settle();
        checks++; if (err_cnt !== 16'd2 || phv_out_valid !== 1'b0 || readies() !== 4'b0000 || m_axis_tvalid !== 1'b0)
            begin errors++; $display("FAIL disc_multi got err%0d pov%b rdy%b mv%b exp 2 0 0000 0", err_cnt, phv_out_valid, readies(), m_axis_tvalid); end
        tick();
        settle();
        checks++; if (err_cnt !== 16'd2 || readies() !== 4'b0000) begin errors++; $display("FAIL disc_hold got err%0d rdy%b exp 2 0000", err_cnt, readies()); end
        for (int q = 0; q < 4; q++) set_beat(q, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        set_beat(1, 16'h5111, 1'b1, 1'b1);
        set_beat(2, 16'h5200, 1'b0, 1'b1);
        phv_in = mk_phv(4'b0100, 16'h5000); phv_in_valid = 1'b1; m_axis_tready = 1'b1;
        tick();
        phv_in_valid = 1'b0;
        settle();
        checks++; if (m_axis_tdata !== {16{16'h5200}} || tr[2] !== 1'b1 || tr[1] !== 1'b0)
            begin errors++; $display("FAIL stall_b0 got d%h tr2%b tr1%b exp 5200 1 0", m_axis_tdata[15:0], tr[2], tr[1]); end
        tick();
        set_beat(2, 16'h5201, 1'b1, 1'b1); m_axis_tready = 1'b0;
        settle();
        checks++; if (m_axis_tdata !== {16{16'h5201}} || tr[2] !== 1'b0 || tr[1] !== 1'b0 || phv_out_valid !== 1'b1)
            begin errors++; $display("FAIL stall_b1_low got d%h tr2%b tr1%b pov%b exp 5201 0 0 1", m_axis_tdata[15:0], tr[2], tr[1], phv_out_valid); end
        tick();
        m_axis_tready = 1'b1;
        settle();
        checks++; if (m_axis_tdata !== {16{16'h5201}} || m_axis_tlast !== 1'b1 || tr[2] !== 1'b1 || tr[1] !== 1'b0 || phv_in_ready !== 1'b0)
            begin errors++; $display("FAIL stall_b1_high got d%h l%b tr2%b tr1%b pir%b exp 5201 1 1 0 0", m_axis_tdata[15:0], m_axis_tlast, tr[2], tr[1], phv_in_ready); end
        tick();
        set_beat(2, 16'h0, 1'b0, 1'b0); m_axis_tready = 1'b0;
        settle();
        checks++; if (phv_in_ready !== 1'b1 || tr[1] !== 1'b0 || phv_out_valid !== 1'b0)
            begin errors++; $display("FAIL stall_end got pir%b tr1%b pov%b exp 1 0 0", phv_in_ready, tr[1], phv_out_valid); end
        set_beat(1, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_packet();
        logic [HL-1:0] zero_phv;
        zero_phv = '0;
        phv_in = mk_phv(4'b0001, 16'h7000); phv_in_valid = 1'b1; m_axis_tready = 1'b1;
        set_beat(0, 16'h7100, 1'b0, 1'b1);
        tick();
        phv_in_valid = 1'b0;
        tick();
        set_beat(0, 16'h7101, 1'b0, 1'b1);
        settle();
        checks++; if (m_axis_tdata !== {16{16'h7101}} || phv_out_valid !== 1'b1 || err_cnt !== 16'd2)
            begin errors++; $display("FAIL rstmid_pre got d%h pov%b err%0d exp 7101 1 2", m_axis_tdata[15:0], phv_out_valid, err_cnt); end
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        settle();
        checks++; if (phv_in_ready !== 1'b1 || phv_out_valid !== 1'b0 || err_cnt !== 16'd0 || phv_out !== zero_phv)
            begin errors++; $display("FAIL rstmid_ctl got pir%b pov%b err%0d exp 1 0 0", phv_in_ready, phv_out_valid, err_cnt); end
        checks++; if (readies() !== 4'b0000 || m_axis_tvalid !== 1'b0)
            begin errors++; $display("FAIL rstmid_rdy got rdy%b mv%b exp 0000 0", readies(), m_axis_tvalid); end
        clear_inputs();
    endtask

`ifdef QUEUE_ORDER_CHECK_EN
    task automatic test_order_check();
        m_axis_tready = 1'b1;
        phv_in = mk_phv(4'b0001, 16'h9000); phv_in_valid = 1'b1;
        set_beat(0, 16'h9100, 1'b1, 1'b1);
        set_beat(1, 16'h9101, 1'b1, 1'b1);
        set_beat(2, 16'h9102, 1'b1, 1'b1);
        tick();
        phv_in_valid = 1'b0;
        settle();
        checks++; if (phv_out_valid !== 1'b1 || m_axis_tdata !== {16{16'h9100}})
            begin errors++; $display("FAIL ord_first got pov%b d%h exp 1 9100", phv_out_valid, m_axis_tdata[15:0]); end
        tick();
        set_beat(0, 16'h0, 1'b0, 1'b0);
        phv_in = mk_phv(4'b0100, 16'h9001); phv_in_valid = 1'b1;
        tick();
        phv_in = mk_phv(4'b0010, 16'h9002);
        settle();
        checks++; if (err_cnt !== 16'd1 || phv_in_ready !== 1'b1 || readies() !== 4'b0000)
            begin errors++; $display("FAIL ord_skip got err%0d pir%b rdy%b exp 1 1 0000", err_cnt, phv_in_ready, readies()); end
        tick();
        phv_in_valid = 1'b0;
        settle();
        checks++; if (phv_out_valid !== 1'b1 || readies() !== 4'b0010 || m_axis_tdata !== {16{16'h9101}} || err_cnt !== 16'd1)
            begin errors++; $display("FAIL ord_next got pov%b rdy%b d%h err%0d exp 1 0010 9101 1", phv_out_valid, readies(), m_axis_tdata[15:0], err_cnt); end
        tick();
        clear_inputs();
    endtask
`endif

    initial begin
        clear_inputs();
        aresetn = 1'b0;
        test_reset();
`ifdef QUEUE_ORDER_CHECK_EN
        test_order_check();
`else
        test_three_beat();
        test_back_to_back();
        test_discard();
        test_stall();
        test_reset_mid_packet();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
